// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle A - B, one 4-bit nibble per clock, LSB nibble first, with valid/ready on both sides.
// Optional SUB_SIGNED_OVF_EN adds a registered two's-complement overflow output.
module nibble_serial_subtractor #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   diff,
   output logic                   borrow,
`ifdef SUB_SIGNED_OVF_EN
   output logic                   overflow,
`endif
   output logic                   busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_reg, b_reg;
   logic [IW-1:0]   idx;
   logic [IW+1:0]   base;
   logic            borrow_reg;
   logic [3:0]      nib_a, nib_b;
   logic [4:0]      r;
   logic            last;

   // Datapath for the current nibble: 5-bit subtract, bit 4 is the borrow out.
   always_comb begin
      base  = {idx, 2'b00};
      nib_a = a_reg[base +: 4];
      nib_b = b_reg[base +: 4];
      r     = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, borrow_reg};
      last  = (idx == IW'(NIBBLES - 1));
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         idx        <= '0;
         borrow_reg <= 1'b0;
         diff       <= '0;
         borrow     <= 1'b0;
         out_valid  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
         overflow   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_reg      <= a;
                  b_reg      <= b;
                  idx        <= '0;
                  borrow_reg <= 1'b0;
               end
            end
            RUN: begin
               diff[base +: 4] <= r[3:0];
               borrow_reg      <= r[4];
               idx             <= idx + 1'b1;
               if (last) begin
                  borrow    <= r[4];
                  out_valid <= 1'b1;
`ifdef SUB_SIGNED_OVF_EN
                  // r[3] is the final diff MSB being written on this same edge.
                  overflow  <= (a_reg[W-1] != b_reg[W-1]) && (r[3] != a_reg[W-1]);
`endif
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
